// File: rtl/fp32_pkg.sv
// Shared definitions for the FP32 divider: field widths, FSM states and the operand field layout.
package fp32_pkg;
    localparam int         EXP_W   = 8;
    localparam int         MANT_W  = 23;
    localparam int         BIAS    = 127;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] frac;
    } fp32_t;
endpackage

// File: rtl/fp32_div_round.sv
// Normalise, round and pack the raw quotient; FPDIV_ROUND_NEAREST_EN selects RNE, otherwise truncation.
module fp32_div_round
    import fp32_pkg::*;
(
    input  logic [MANT_W+2:0]  q,
    input  logic               r_nz,
    input  logic               sign,
    input  logic signed [9:0]  e_base,
    output logic [31:0]        result,
    output logic               overflow,
    output logic               underflow
);
    logic [MANT_W-1:0] mant;
    logic [MANT_W:0]   mant_rnd;
    logic signed [9:0] e;
`ifdef FPDIV_ROUND_NEAREST_EN
    logic rnd, sticky;
`else
    logic unused_trunc;
    assign unused_trunc = ^{q[0], r_nz};
`endif

    always_comb begin
        mant = q[MANT_W+2] ? q[MANT_W+1:2] : q[MANT_W:1];
`ifdef FPDIV_ROUND_NEAREST_EN
        rnd      = q[MANT_W+2] ? q[1] : q[0];
        sticky   = q[MANT_W+2] ? (q[0] | r_nz) : r_nz;
        mant_rnd = {1'b0, mant} + (MANT_W+1)'(rnd & (sticky | mant[0]));
`else
        mant_rnd = {1'b0, mant};
`endif
        e = e_base + 10'(q[MANT_W+2]);
        // A carry out of the mantissa leaves the stored fraction all zero.
        if (mant_rnd[MANT_W])
            e = e + 10'sd1;

        overflow  = 1'b0;
        underflow = 1'b0;
        if (e >= 10'sd255) begin
            overflow = 1'b1;
            result   = {sign, EXP_MAX, {MANT_W{1'b0}}};
        end else if (e <= 10'sd0) begin
            underflow = 1'b1;
            result    = {sign, 31'd0};
        end else begin
            result = {sign, e[7:0], mant_rnd[MANT_W-1:0]};
        end
    end
endmodule

// File: rtl/fp32_divider.sv
// Sequential FP32 divider: restoring division, one quotient bit per cycle, valid/ready on both sides.
// Optional macro FPDIV_ROUND_NEAREST_EN enables round-to-nearest-even (default: truncation).
module fp32_divider #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int BIAS   = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow,
    output logic        DivByZero
);
    import fp32_pkg::*;

    localparam int ITERS = MANT_W + 3;

    state_t              state, state_nxt;
    fp32_t               a_f, b_f;
    logic [MANT_W:0]     mb_q;
    logic [MANT_W+1:0]   r_q, r_sub;
    logic [ITERS-1:0]    q_q;
    logic [4:0]          cnt;
    logic                sign_q, r_ge, accept;
    logic                a_exc, b_exc, a_zero, b_zero, special;
    logic signed [9:0]   e_q;
    logic [31:0]         rnd_result;
    logic                rnd_ovf, rnd_unf;

    assign a_f     = a_operand;
    assign b_f     = b_operand;
    assign a_exc   = (a_f.exp == EXP_MAX);
    assign b_exc   = (b_f.exp == EXP_MAX);
    assign a_zero  = (a_f.exp == '0);
    assign b_zero  = (b_f.exp == '0);
    assign special = a_exc | b_exc | a_zero | b_zero;
    assign accept  = in_valid && (state == IDLE);

    assign r_ge  = (r_q >= {1'b0, mb_q});
    assign r_sub = r_ge ? (r_q - {1'b0, mb_q}) : r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = special ? DONE : DIV;
            end
            DIV:   if (cnt == 5'(ITERS - 1)) state_nxt = ROUND;
            ROUND: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb_q      <= '0;
            r_q       <= '0;
            q_q       <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            e_q       <= '0;
            result    <= '0;
            Exception <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            DivByZero <= 1'b0;
        end else if (accept) begin
            sign_q    <= a_f.sign ^ b_f.sign;
            mb_q      <= {1'b1, b_f.frac};
            r_q       <= {2'b01, a_f.frac};
            q_q       <= '0;
            cnt       <= '0;
            e_q       <= {2'b00, a_f.exp} - {2'b00, b_f.exp} + 10'(BIAS - 1);
            Exception <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            DivByZero <= 1'b0;
            // Special operands bypass the iteration and land in DONE directly.
            if (a_exc || b_exc) begin
                result    <= '0;
                Exception <= 1'b1;
            end else if (a_zero && b_zero) begin
                result <= {a_f.sign ^ b_f.sign, 31'd0};
            end else if (b_zero) begin
                result    <= {a_f.sign ^ b_f.sign, EXP_MAX, {MANT_W{1'b0}}};
                DivByZero <= 1'b1;
            end else if (a_zero) begin
                result <= {a_f.sign ^ b_f.sign, 31'd0};
            end
        end else if (state == DIV) begin
            r_q <= {r_sub[MANT_W:0], 1'b0};
            q_q <= {q_q[ITERS-2:0], r_ge};
            cnt <= cnt + 5'd1;
        end else if (state == ROUND) begin
            result    <= rnd_result;
            Overflow  <= rnd_ovf;
            Underflow <= rnd_unf;
        end
    end

    fp32_div_round u_round (
        .q         (q_q),
        .r_nz      (|r_q),
        .sign      (sign_q),
        .e_base    (e_q),
        .result    (rnd_result),
        .overflow  (rnd_ovf),
        .underflow (rnd_unf)
    );
endmodule

// File: tb/tb_fp32_divider.sv
// Scoreboard bench for fp32_divider: directed vectors push expectations, a monitor checks each output.
module tb_fp32_divider;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a_operand, b_operand, result;
    logic        Exception, Overflow, Underflow, DivByZero;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;
    logic ov_prev = 1'b0;

    fp32_divider #(.EXP_W(8), .MANT_W(23), .BIAS(127)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_operand(a_operand), .b_operand(b_operand), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .Exception(Exception),
        .Overflow(Overflow), .Underflow(Underflow), .DivByZero(DivByZero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: latency on the rising edge of out_valid, data/flags at the handoff.
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0)
                    check("unexpected_output", 32'd1, 32'd0);
                else
                    check({sb[0].name, "_latency"}, 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                check({sb[0].name, "_result"}, result, sb[0].res);
                check({sb[0].name, "_flags"}, {28'd0, Exception, Overflow, Underflow, DivByZero},
                      {28'd0, sb[0].flags});
                void'(sb.pop_front());
            end
            ov_prev = out_valid;
        end
    end

    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [3:0] f, input int lat);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check({name, "_in_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        a_operand = a;
        b_operand = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.name = name; e.res = r; e.flags = f; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            check({name, "_output_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    // flags order: {Exception, Overflow, Underflow, DivByZero}
    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_operand = '0; b_operand = '0;
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {28'd0, Exception, Overflow, Underflow, DivByZero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue("div_6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
        drain("div_6_2");
        issue("div_m6_2", 32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 28);
        drain("div_m6_2");
`ifdef FPDIV_ROUND_NEAREST_EN
        issue("div_1_3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28);
`else
        issue("div_1_3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 28);
`endif
        drain("div_1_3");
        issue("div_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001, 1);
        drain("div_by_zero");
        issue("neg_div_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0001, 1);
        drain("neg_div_by_zero");
        issue("zero_by_zero", 32'h80000000, 32'h00000000, 32'h80000000, 4'b0000, 1);
        drain("zero_by_zero");
        issue("zero_dividend", 32'h00000000, 32'hC0000000, 32'h80000000, 4'b0000, 1);
        drain("zero_dividend");
        issue("exception", 32'h7F800000, 32'h3F800000, 32'h00000000, 4'b1000, 1);
        drain("exception");
        issue("exc_over_zero", 32'h3F800000, 32'hFF800000, 32'h00000000, 4'b1000, 1);
        drain("exc_over_zero");
        issue("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0100, 28);
        drain("overflow");
        issue("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 4'b0010, 28);
        drain("underflow");

        // Back-pressure: DONE must hold steady and ignore new requests.
        @(posedge clk); #1 out_ready = 1'b0;
        issue("stall", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("stall_reached_done", {31'd0, out_valid}, 32'd1);
        for (int unsigned i = 0; i < 5; i++) begin
            a_operand = 32'h3F800000; b_operand = 32'h00000000; in_valid = 1'b1;
            @(negedge clk);
            check("stall_result", result, 32'h40400000);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_flags", {28'd0, Exception, Overflow, Underflow, DivByZero}, 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("handoff_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("post_handoff_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_handoff_out_valid", {31'd0, out_valid}, 32'd0);
        drain("stall");

        // Abort mid-division with reset; no output may appear.
        @(negedge clk);
        a_operand = 32'h3F800000; b_operand = 32'h40400000; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_output", {31'd0, out_valid}, 32'd0);
        issue("div_10_5", 32'h41200000, 32'h40A00000, 32'h40000000, 4'b0000, 28);
        drain("div_10_5");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
